run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/cdec_pkg.sv | 42 ++++
 rtl/mem_port_mux.sv | 34 +++
 rtl/run_controller.sv | 169 ++++++++++++++++
 tb/tb_run_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdec_pkg.sv
// cdec_pkg: shared definitions for the CPU debug/run-control slice.
//   - CPU state codes reported by the core on its 8-bit 'state' bus
//   - run_controller FSM encoding
//   - helper mapping the controller FSM onto the 2-bit status code
package cdec_pkg;

   // CPU micro-state codes (fetch phases, memory phase, halt)
   localparam logic [7:0] state_F0  = 8'h00;
   localparam logic [7:0] state_F1  = 8'h01;
   localparam logic [7:0] state_F2  = 8'h02;
   localparam logic [7:0] state_M0  = 8'h03;
   localparam logic [7:0] state_M1  = 8'h04;
   localparam logic [7:0] state_HLT = 8'hFF;

   // Run-controller FSM
   typedef enum logic [2:0] {
      RC_IDLE   = 3'd0,
      RC_RUN    = 3'd1,
      RC_STEP   = 3'd2,
      RC_MEMACC = 3'd3,
      RC_HALTED = 3'd4
   } rc_state_e;

   // Externally visible status codes
   localparam logic [1:0] STATUS_IDLE   = 2'd0;
   localparam logic [1:0] STATUS_RUN    = 2'd1;
   localparam logic [1:0] STATUS_STEP   = 2'd2;
   localparam logic [1:0] STATUS_HALTED = 2'd3;

   // MEMACC is transparent to the monitor: report the state it returns to.
   function automatic logic [1:0] rc_status(input rc_state_e cur, input rc_state_e ret);
      rc_state_e eff;
      eff = (cur == RC_MEMACC) ? ret : cur;
      case (eff)
         RC_RUN:    rc_status = STATUS_RUN;
         RC_STEP:   rc_status = STATUS_STEP;
         RC_HALTED: rc_status = STATUS_HALTED;
         default:   rc_status = STATUS_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux: combinational selection of the shared memory port.
//   sel_mon_i      1 = monitor owns the port (MEMACC), 0 = CPU owns it
//   cpu_en_i       CPU clock enable; CPU writes are gated by it
//   mon_*_i        monitor request (addr, we, wdata)
//   cpu_*_i        CPU request (addr, we, wdata)
//   mem_*_o        memory port outputs
module mem_port_mux (
   input  logic       sel_mon_i,
   input  logic       cpu_en_i,
   input  logic [7:0] mon_addr_i,
   input  logic       mon_we_i,
   input  logic [7:0] mon_wdata_i,
   input  logic [7:0] cpu_addr_i,
   input  logic       cpu_we_i,
   input  logic [7:0] cpu_wdata_i,
   output logic [7:0] mem_addr_o,
   output logic       mem_we_o,
   output logic [7:0] mem_wdata_o
);

   // Port ownership; a frozen CPU can never write memory.
   always_comb begin
      if (sel_mon_i) begin
         mem_addr_o  = mon_addr_i;
         mem_we_o    = mon_we_i;
         mem_wdata_o = mon_wdata_i;
      end else begin
         mem_addr_o  = cpu_addr_i;
         mem_we_o    = cpu_we_i & cpu_en_i;
         mem_wdata_o = cpu_wdata_i;
      end
   end

endmodule

// File: rtl/run_controller.sv
// run_controller: debug run control for a small CPU.
//   clk, reset                 clock, asynchronous active-high reset
//   run_req/step_req/halt_req  single-cycle monitor commands
//   bp_en, bp_addr             PC breakpoint
//   pc, state                  CPU program counter and micro-state code
//   mon_req/addr/we/wdata      monitor memory request, held until mon_ack
//   mon_ack, mon_rdata         one-cycle completion pulse and read data
//   cpu_mem_*                  CPU memory port
//   mem_*                      shared combinational-read memory port
//   cpu_en                     CPU state/register clock enable
//   status                     0 IDLE, 1 RUN, 2 STEP, 3 HALTED
module run_controller
   import cdec_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       run_req,
   input  logic       step_req,
   input  logic       halt_req,
   input  logic       bp_en,
   input  logic [7:0] bp_addr,
   input  logic [7:0] pc,
   input  logic [7:0] state,
   input  logic       mon_req,
   input  logic [7:0] mon_addr,
   input  logic       mon_we,
   input  logic [7:0] mon_wdata,
   output logic       mon_ack,
   output logic [7:0] mon_rdata,
   input  logic [7:0] cpu_mem_addr,
   input  logic       cpu_mem_we,
   input  logic [7:0] cpu_mem_wdata,
   output logic [7:0] mem_addr,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       cpu_en,
   output logic [1:0] status
);

   rc_state_e  fsm_q, fsm_d;
   rc_state_e  ret_q, ret_d;
   logic       first_q, first_d;
   logic       halt_pend_q, halt_pend_d;
   logic       mon_ack_q, mon_ack_d;
   logic [7:0] mon_rdata_q, mon_rdata_d;
   logic       cpu_en_s;
   logic       boundary_s;
   logic       hlt_s;
   logic       bp_hit_s;
   logic       grant_s;

   assign boundary_s = (state == state_F0);
   assign hlt_s      = (state == state_HLT);
   assign bp_hit_s   = bp_en && (pc == bp_addr);
   // No regrant while the previous access is still being acknowledged.
   assign grant_s    = mon_req && !mon_ack_q;

   // Next-state, flag and clock-enable logic.
   always_comb begin
      fsm_d       = fsm_q;
      ret_d       = ret_q;
      first_d     = first_q;
      halt_pend_d = halt_pend_q;
      cpu_en_s    = 1'b0;
      case (fsm_q)
         RC_IDLE: begin
            if (grant_s) begin
               fsm_d = RC_MEMACC;
               ret_d = RC_IDLE;
            end else if (step_req) begin
               // step wins over a simultaneous run
               fsm_d   = RC_STEP;
               first_d = 1'b1;
            end else if (run_req) begin
               fsm_d   = RC_RUN;
               first_d = 1'b1;
            end else begin
               fsm_d = RC_IDLE;
            end
         end
         RC_RUN, RC_STEP: begin
            if (halt_req) begin
               halt_pend_d = 1'b1;
            end else begin
               halt_pend_d = halt_pend_q;
            end
            if (hlt_s) begin
               fsm_d = RC_HALTED;
            end else if (boundary_s && !first_q &&
                         ((fsm_q == RC_STEP) || halt_pend_q || bp_hit_s)) begin
               // first suppresses the boundary we resumed from
               fsm_d       = RC_IDLE;
               halt_pend_d = 1'b0;
            end else begin
               cpu_en_s = 1'b1;
               first_d  = 1'b0;
            end
         end
         RC_MEMACC: begin
            fsm_d = ret_q;
         end
         RC_HALTED: begin
            if (grant_s) begin
               fsm_d = RC_MEMACC;
               ret_d = RC_HALTED;
            end else begin
               fsm_d = RC_HALTED;
            end
         end
         default: begin
            fsm_d = RC_IDLE;
            ret_d = RC_IDLE;
         end
      endcase
   end

   // Monitor completion: capture read data at the end of MEMACC, ack next cycle.
   always_comb begin
      if (fsm_q == RC_MEMACC) begin
         mon_ack_d   = 1'b1;
         mon_rdata_d = mem_rdata;
      end else begin
         mon_ack_d   = 1'b0;
         mon_rdata_d = mon_rdata_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q       <= RC_IDLE;
         ret_q       <= RC_IDLE;
         first_q     <= 1'b0;
         halt_pend_q <= 1'b0;
         mon_ack_q   <= 1'b0;
         mon_rdata_q <= 8'h00;
      end else begin
         fsm_q       <= fsm_d;
         ret_q       <= ret_d;
         first_q     <= first_d;
         halt_pend_q <= halt_pend_d;
         mon_ack_q   <= mon_ack_d;
         mon_rdata_q <= mon_rdata_d;
      end
   end

   // cpu_en must drop in the boundary cycle itself, so it is decoded
   // from the state register and the live CPU state rather than registered.
   assign cpu_en    = cpu_en_s;
   assign mon_ack   = mon_ack_q;
   assign mon_rdata = mon_rdata_q;
   assign status    = rc_status(fsm_q, ret_q);

   mem_port_mux u_mem_port_mux (
      .sel_mon_i   (fsm_q == RC_MEMACC),
      .cpu_en_i    (cpu_en_s),
      .mon_addr_i  (mon_addr),
      .mon_we_i    (mon_we),
      .mon_wdata_i (mon_wdata),
      .cpu_addr_i  (cpu_mem_addr),
      .cpu_we_i    (cpu_mem_we),
      .cpu_wdata_i (cpu_mem_wdata),
      .mem_addr_o  (mem_addr),
      .mem_we_o    (mem_we),
      .mem_wdata_o (mem_wdata)
   );

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: self-checking bench for run_controller with a small
// CPU model (F0->F1->F2->M0 per instruction) and a combinational memory.
module tb_run_controller;
   import cdec_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
   logic       bp_en = 1'b0;
   logic [7:0] bp_addr = 8'h00;
   logic [7:0] cpu_pc = 8'h00;
   logic [7:0] cpu_st = 8'h00;
   logic       mon_req = 1'b0, mon_we = 1'b0;
   logic [7:0] mon_addr = 8'h00, mon_wdata = 8'h00;
   logic       mon_ack;
   logic [7:0] mon_rdata;
   logic [7:0] cpu_mem_addr = 8'h77, cpu_mem_wdata = 8'h3C;
   logic       cpu_mem_we = 1'b0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we;
   logic       cpu_en;
   logic [1:0] status;

   logic       ld = 1'b0;
   logic [7:0] ld_pc = 8'h00, ld_st = 8'h00;
   logic [7:0] mem [256];
   logic [7:0] shadow [256];
   logic [7:0] exp_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   run_controller dut (
      .clk(clk), .reset(reset),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(cpu_pc), .state(cpu_st),
      .mon_req(mon_req), .mon_addr(mon_addr), .mon_we(mon_we), .mon_wdata(mon_wdata),
      .mon_ack(mon_ack), .mon_rdata(mon_rdata),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_we(cpu_mem_we), .cpu_mem_wdata(cpu_mem_wdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_en(cpu_en), .status(status)
   );

   // CPU model: advances only when enabled; a bench load overrides it.
   always @(posedge clk) begin
      if (ld) begin
         cpu_pc <= ld_pc;
         cpu_st <= ld_st;
      end else if (cpu_en) begin
         case (cpu_st)
            state_F0: cpu_st <= state_F1;
            state_F1: cpu_st <= state_F2;
            state_F2: cpu_st <= state_M0;
            state_M0: begin cpu_st <= state_F0; cpu_pc <= cpu_pc + 8'd1; end
            default:  cpu_st <= cpu_st;
         endcase
      end
   end

   // Memory model: combinational read, synchronous write.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic load_cpu(input logic [7:0] p, input logic [7:0] s);
      ld_pc = p; ld_st = s; ld = 1'b1;
      cycle();
      ld = 1'b0;
   endtask

   // Request a halt and wait for the controller to freeze, then settle in IDLE.
   task automatic stop_run();
      bit done;
      halt_req = 1'b1;
      cycle();
      halt_req = 1'b0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (!cpu_en) done = 1;
         else cycle();
      end
      checks++;
      if (!done) begin errors++; $display("FAIL stop_timeout: cpu_en stayed 1, required 0 within 20 cycles"); end
      cycle();
   endtask

   task automatic test_reset();
      cpu_mem_we = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (status !== 2'd0) begin errors++; $display("FAIL reset_status: got %0d required 0", status); end
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b required 0", cpu_en); end
      checks++; if (mon_ack !== 1'b0) begin errors++; $display("FAIL reset_mon_ack: got %0b required 0", mon_ack); end
      checks++; if (mon_rdata !== 8'h00) begin errors++; $display("FAIL reset_mon_rdata: got %0h required 00", mon_rdata); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b required 0", mem_we); end
      cpu_mem_we = 1'b0;
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_halt();
      int cnt; bit done; bit ok;
      load_cpu(8'h00, state_F0);
      run_req = 1'b1; cycle(); run_req = 1'b0;
      checks++; if (status !== 2'd1) begin errors++; $display("FAIL halt_run_status: got %0d required 1", status); end
      cycle();   // F0 -> F1
      halt_req = 1'b1; cycle(); halt_req = 1'b0;
      cnt = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cpu_en) begin cnt++; cycle(); end
         else done = 1;
      end
      checks++; if (!done || cnt != 2) begin errors++; $display("FAIL halt_latency: got %0d enabled cycles required 2", cnt); end
      checks++; if (cpu_st !== state_F0 || cpu_pc !== 8'h01) begin errors++; $display("FAIL halt_at_f0: got st=%0h pc=%0h required st=00 pc=01", cpu_st, cpu_pc); end
      cycle();
      checks++; if (status !== 2'd0 || cpu_en !== 1'b0) begin errors++; $display("FAIL halt_idle: got status=%0d cpu_en=%0b required 0/0", status, cpu_en); end
      // halt_pend must be gone: a new run passes the next boundary
      run_req = 1'b1; cycle(); run_req = 1'b0;
      ok = 1;
      for (int i = 0; i < 6; i++) begin
         if (cpu_en !== 1'b1) ok = 0;
         cycle();
      end
      checks++; if (!ok || cpu_pc !== 8'h02) begin errors++; $display("FAIL halt_pend_clear: got ok=%0b pc=%0h required 1/02", ok, cpu_pc); end
      stop_run();
   endtask

   task automatic test_step();
      int cnt; bit done;
      load_cpu(8'h10, state_F0);
      step_req = 1'b1; cycle(); step_req = 1'b0;
      checks++; if (status !== 2'd2) begin errors++; $display("FAIL step_status: got %0d required 2", status); end
      cnt = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cpu_en) begin cnt++; cycle(); end
         else done = 1;
      end
      checks++; if (!done || cnt != 4) begin errors++; $display("FAIL step_cycles: got %0d required 4", cnt); end
      checks++; if (cpu_pc !== 8'h11) begin errors++; $display("FAIL step_pc: got %0h required 11", cpu_pc); end
      cycle();
      checks++; if (status !== 2'd0) begin errors++; $display("FAIL step_idle: got %0d required 0", status); end
   endtask

   task automatic test_breakpoint();
      int cnt; bit done; bit ok;
      bp_en = 1'b1; bp_addr = 8'h05;
      load_cpu(8'h00, state_F0);
      run_req = 1'b1; cycle(); run_req = 1'b0;
      cnt = 0; done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (cpu_en) begin cnt++; cycle(); end
         else done = 1;
      end
      checks++; if (!done || cnt != 20) begin errors++; $display("FAIL bp_cycles: got %0d required 20", cnt); end
      checks++; if (cpu_pc !== 8'h05 || cpu_st !== state_F0) begin errors++; $display("FAIL bp_stop: got pc=%0h st=%0h required 05/00", cpu_pc, cpu_st); end
      cycle();
      checks++; if (status !== 2'd0) begin errors++; $display("FAIL bp_idle: got %0d required 0", status); end
      run_req = 1'b1; cycle(); run_req = 1'b0;
      ok = 1;
      for (int i = 0; i < 5; i++) begin
         if (cpu_en !== 1'b1) ok = 0;
         cycle();
      end
      checks++; if (!ok || cpu_pc !== 8'h06) begin errors++; $display("FAIL bp_resume: got ok=%0b pc=%0h required 1/06", ok, cpu_pc); end
      bp_en = 1'b0;
      stop_run();
   endtask

   task automatic test_back_to_back();
      int cnt; bit done;
      load_cpu(8'h60, state_F0);
      run_req = 1'b1; step_req = 1'b1; cycle(); run_req = 1'b0; step_req = 1'b0;
      checks++; if (status !== 2'd2) begin errors++; $display("FAIL both_req_status: got %0d required 2", status); end
      cnt = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cpu_en) begin cnt++; cycle(); end
         else done = 1;
      end
      checks++; if (!done || cnt != 4 || cpu_pc !== 8'h61) begin errors++; $display("FAIL both_req_step: got cycles=%0d pc=%0h required 4/61", cnt, cpu_pc); end
      cycle();
   endtask

   task automatic test_mem();
      logic [7:0] addrs [3];
      logic       wes   [3];
      logic [7:0] datas [3];
      logic [7:0] want;
      addrs = '{8'h20, 8'h50, 8'h20};
      wes   = '{1'b1, 1'b1, 1'b0};
      datas = '{8'hA5, 8'h00, 8'h5A};
      for (int k = 0; k < 3; k++) begin
         mon_req = 1'b1; mon_addr = addrs[k]; mon_we = wes[k]; mon_wdata = datas[k];
         if (wes[k]) shadow[addrs[k]] = datas[k];
         else exp_q.push_back(shadow[addrs[k]]);
         cycle();   // MEMACC
         checks++; if (mem_we !== wes[k] || mem_addr !== addrs[k]) begin errors++; $display("FAIL mem_access%0d: got we=%0b addr=%0h required %0b/%0h", k, mem_we, mem_addr, wes[k], addrs[k]); end
         cycle();   // ack cycle
         checks++; if (mon_ack !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL mem_ack%0d: got ack=%0b we=%0b required 1/0", k, mon_ack, mem_we); end
         if (!wes[k]) begin
            want = exp_q.pop_front();
            checks++; if (mon_rdata !== want) begin errors++; $display("FAIL mem_rdata: got %0h required %0h", mon_rdata, want); end
         end
         cycle();   // request still held during the ack edge
         mon_req = 1'b0;
         checks++; if (mon_ack !== 1'b0 || mem_addr !== cpu_mem_addr) begin errors++; $display("FAIL mem_no_regrant%0d: got ack=%0b addr=%0h required 0/%0h", k, mon_ack, mem_addr, cpu_mem_addr); end
      end
   endtask

   task automatic test_halted();
      logic [7:0] want;
      load_cpu(8'h30, state_F0);
      run_req = 1'b1; cycle(); run_req = 1'b0;
      cycle(); cycle();
      load_cpu(8'h31, state_HLT);
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL hlt_cpu_en: got %0b required 0", cpu_en); end
      cycle();
      checks++; if (status !== 2'd3) begin errors++; $display("FAIL hlt_status: got %0d required 3", status); end
      run_req = 1'b1; cycle(); run_req = 1'b0;
      step_req = 1'b1; cycle(); step_req = 1'b0;
      cycle();
      checks++; if (status !== 2'd3 || cpu_en !== 1'b0) begin errors++; $display("FAIL hlt_ignore_cmd: got status=%0d cpu_en=%0b required 3/0", status, cpu_en); end
      cpu_mem_we = 1'b1; #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hlt_cpu_write: got mem_we=%0b required 0", mem_we); end
      mon_req = 1'b1; mon_addr = 8'h20; mon_we = 1'b0;
      exp_q.push_back(shadow[8'h20]);
      cycle();
      checks++; if (status !== 2'd3 || mem_we !== 1'b0) begin errors++; $display("FAIL hlt_memacc: got status=%0d we=%0b required 3/0", status, mem_we); end
      cycle();
      want = exp_q.pop_front();
      checks++; if (mon_ack !== 1'b1 || mon_rdata !== want) begin errors++; $display("FAIL hlt_read: got ack=%0b rdata=%0h required 1/%0h", mon_ack, mon_rdata, want); end
      cycle();
      mon_req = 1'b0; cpu_mem_we = 1'b0;
      checks++; if (status !== 2'd3) begin errors++; $display("FAIL hlt_return: got %0d required 3", status); end
   endtask

   task automatic test_reset_memacc();
      mon_req = 1'b1; mon_addr = 8'h50; mon_we = 1'b1; mon_wdata = 8'h11;
      cycle();
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_memacc: got mem_we=%0b required 1", mem_we); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0 || mon_ack !== 1'b0 || status !== 2'd0) begin errors++; $display("FAIL rst_memacc: got we=%0b ack=%0b status=%0d required 0/0/0", mem_we, mon_ack, status); end
      mon_req = 1'b0; mon_we = 1'b0;
      cycle(); cycle();
      checks++; if (mem[8'h50] !== 8'h00) begin errors++; $display("FAIL rst_no_write: got mem[50]=%0h required 00", mem[8'h50]); end
      @(negedge clk) reset = 1'b0;
      cycle();
      checks++; if (status !== 2'd0 || mon_ack !== 1'b0) begin errors++; $display("FAIL rst_after: got status=%0d ack=%0b required 0/0", status, mon_ack); end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_step();
      test_breakpoint();
      test_back_to_back();
      test_mem();
      test_halted();
      test_reset_memacc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
